// File: rtl/replay_pkg.sv
// rtl/replay_pkg.sv - shared types, constants and sequence arithmetic for the replay controller
// Contents: SEQ_W, DLLP type codes, FSM state enum, seq_diff() modulo subtract.
package replay_pkg;

    localparam int SEQ_W = 12;

    localparam logic [1:0] DLLP_NONE = 2'b00;
    localparam logic [1:0] DLLP_ACK  = 2'b01;
    localparam logic [1:0] DLLP_NAK  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REPLAY  = 2'd1,
        ST_RETRAIN = 2'd2
    } state_t;

    // (a - b) mod 2^SEQ_W; the natural wrap of the fixed-width subtract does the modulo.
    function automatic logic [SEQ_W-1:0] seq_diff(input logic [SEQ_W-1:0] a,
                                                  input logic [SEQ_W-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/replay_ctrl_if.sv
// rtl/replay_ctrl_if.sv - handshake/bus bundle between the replay controller and its environment
// Groups: TLP accept (tx_*), buffer addressing (buf_*), AckNak input (dllp_*),
// replay stream (rp_*), retrain handshake and status (replay_active, dllp_err, count).
// Modports: master = controller side, slave = link/buffer side.
interface replay_ctrl_if #(
    parameter int DEPTH_LOG2 = 3
);
    import replay_pkg::*;

    logic                  tx_valid;
    logic                  tx_ready;
    logic [SEQ_W-1:0]      tx_seq;
    logic                  buf_we;
    logic [DEPTH_LOG2-1:0] buf_waddr;
    logic                  buf_oe;
    logic [DEPTH_LOG2-1:0] buf_raddr;
    logic                  dllp_valid;
    logic [1:0]            dllp_type;
    logic [SEQ_W-1:0]      dllp_seq;
    logic                  rp_ready;
    logic                  rp_valid;
    logic [SEQ_W-1:0]      rp_seq;
    logic                  replay_active;
    logic                  retrain_req;
    logic                  retrain_done;
    logic                  dllp_err;
    logic [DEPTH_LOG2:0]   count;

    modport master (
        input  tx_valid, dllp_valid, dllp_type, dllp_seq, rp_ready, retrain_done,
        output tx_ready, tx_seq, buf_we, buf_waddr, buf_oe, buf_raddr,
               rp_valid, rp_seq, replay_active, retrain_req, dllp_err, count
    );

    modport slave (
        output tx_valid, dllp_valid, dllp_type, dllp_seq, rp_ready, retrain_done,
        input  tx_ready, tx_seq, buf_we, buf_waddr, buf_oe, buf_raddr,
               rp_valid, rp_seq, replay_active, retrain_req, dllp_err, count
    );

endinterface

// File: rtl/replay_timer.sv
// rtl/replay_timer.sv - replay timer: counts enabled cycles, pulses expire at TIMEOUT-1
// Ports: clk, reset (async active-low), i_clear (highest priority), i_load/i_load_val,
// i_enable (increment), o_expire (combinational, high while enabled at TIMEOUT-1).
module replay_timer #(
    parameter int TIMER_W = 10,
    parameter int TIMEOUT = 700
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_enable,
    output logic               o_expire
);

    logic [TIMER_W-1:0] r_timer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (i_clear) begin
            r_timer <= '0;
        end else if (i_load) begin
            r_timer <= i_load_val;
        end else if (i_enable) begin
            r_timer <= r_timer + TIMER_W'(1);
        end
    end

    assign o_expire = i_enable && (r_timer == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/replay_ctrl.sv
// rtl/replay_ctrl.sv - data-link replay buffer sequencing controller
// Assigns sequence numbers to accepted TLP words, addresses the replay RAM,
// retires entries on ACK, replays on NAK/timeout, escalates to retrain.
// Ports: clk, reset (async active-low), bus (replay_ctrl_if.master: tx_*, buf_*,
// dllp_*, rp_*, retrain_req/retrain_done, replay_active, dllp_err, count).
module replay_ctrl
    import replay_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMER_W    = 10,
    parameter int TIMEOUT    = 700,
    parameter int MAX_REPLAY = 4
) (
    input  logic          clk,
    input  logic          reset,
    replay_ctrl_if.master bus
);

    localparam int               RN_W     = $clog2(MAX_REPLAY + 1);
    localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);
    localparam logic [SEQ_W-1:0] FULL_CNT = SEQ_W'(1 << DEPTH_LOG2);
    localparam logic [RN_W-1:0]  RN_MAX   = RN_W'(MAX_REPLAY);

    state_t           r_state;
    logic [SEQ_W-1:0] r_next_seq;
    logic [SEQ_W-1:0] r_acked_seq;
    logic [SEQ_W-1:0] r_rd_seq;
    logic [RN_W-1:0]  r_replay_num;
    logic             r_tx_ready;
    logic             r_rp_valid;
    logic [SEQ_W-1:0] r_rp_seq;
    logic             r_dllp_err;

    logic [SEQ_W-1:0] w_count;
    logic [SEQ_W-1:0] w_d;
    logic             w_accept;
    logic             w_acknak;
    logic             w_is_nak;
    logic             w_purge;
    logic             w_range_err;
    logic [SEQ_W-1:0] w_acked_nxt;
    logic [SEQ_W-1:0] w_next_seq_nxt;
    logic [SEQ_W-1:0] w_count_nxt;
    logic             w_issue;
    logic [SEQ_W-1:0] w_rd_adv;
    logic             w_rd_jump;
    logic             w_timer_en;
    logic             w_expire;
    logic             w_nak_trig;
    logic             w_trigger;
    logic [RN_W-1:0]  w_rn_base;
    logic [RN_W-1:0]  w_rn_inc;

    state_t           w_state_nxt;
    logic [SEQ_W-1:0] w_rd_nxt;
    logic [RN_W-1:0]  w_rn_nxt;
    logic             w_timer_clr;

    // Occupancy is derived from the two sequence pointers rather than kept separately.
    assign w_count     = seq_diff(r_next_seq, r_acked_seq) - SEQ_ONE;
    assign w_accept    = bus.tx_valid && r_tx_ready;
    assign w_acknak    = bus.dllp_valid && ((bus.dllp_type == DLLP_ACK) || (bus.dllp_type == DLLP_NAK));
    assign w_is_nak    = bus.dllp_valid && (bus.dllp_type == DLLP_NAK);
    assign w_d         = seq_diff(bus.dllp_seq, r_acked_seq);
    assign w_purge     = w_acknak && (w_d != '0) && (w_d <= w_count);
    assign w_range_err = w_acknak && (w_d > w_count);

    assign w_acked_nxt    = w_purge ? bus.dllp_seq : r_acked_seq;
    assign w_next_seq_nxt = w_accept ? (r_next_seq + SEQ_ONE) : r_next_seq;
    assign w_count_nxt    = seq_diff(w_next_seq_nxt, w_acked_nxt) - SEQ_ONE;

    assign w_issue  = (r_state == ST_REPLAY) && bus.rp_ready && (r_rd_seq != r_next_seq);
    assign w_rd_adv = w_issue ? (r_rd_seq + SEQ_ONE) : r_rd_seq;

    // Both distances are measured from the old acked_seq so the compare survives the 4095->0 wrap.
    assign w_rd_jump = w_purge &&
                       (seq_diff(w_acked_nxt, r_acked_seq) >= seq_diff(w_rd_adv, r_acked_seq));

    assign w_timer_en = (r_state == ST_IDLE) && (w_count != '0);

    // A NAK naming acked_seq itself (d==0) purges nothing but still replays everything outstanding.
    assign w_nak_trig = w_is_nak && (w_purge || (w_d == '0)) && (w_count_nxt != '0);
    // Forward progress from an ACK in the expiry cycle wins over the timeout.
    assign w_trigger  = (r_state == ST_IDLE) && (w_nak_trig || (w_expire && !w_purge));

    assign w_rn_base = w_purge ? '0 : r_replay_num;
    assign w_rn_inc  = w_rn_base + RN_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_rd_nxt    = r_rd_seq;
        w_rn_nxt    = w_rn_base;
        w_timer_clr = w_purge || (w_count == '0);
        unique case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    w_timer_clr = 1'b1;
                    if (w_rn_inc == RN_MAX) begin
                        w_state_nxt = ST_RETRAIN;
                    end else begin
                        w_rn_nxt    = w_rn_inc;
                        w_rd_nxt    = w_acked_nxt + SEQ_ONE;
                        w_state_nxt = ST_REPLAY;
                    end
                end
            end
            ST_REPLAY: begin
                w_rd_nxt = w_rd_jump ? (w_acked_nxt + SEQ_ONE) : w_rd_adv;
                // Nothing left to read: either the last entry was issued or an ACK covered the rest.
                if (w_rd_nxt == r_next_seq) begin
                    w_state_nxt = ST_IDLE;
                    w_timer_clr = 1'b1;
                end
            end
            ST_RETRAIN: begin
                if (bus.retrain_done) begin
                    w_rn_nxt    = '0;
                    w_rd_nxt    = w_acked_nxt + SEQ_ONE;
                    w_timer_clr = 1'b1;
                    w_state_nxt = (w_count_nxt != '0) ? ST_REPLAY : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_next_seq   <= '0;
            r_acked_seq  <= '1;
            r_rd_seq     <= '0;
            r_replay_num <= '0;
            r_tx_ready   <= 1'b0;
            r_rp_valid   <= 1'b0;
            r_rp_seq     <= '0;
            r_dllp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_next_seq   <= w_next_seq_nxt;
            r_acked_seq  <= w_acked_nxt;
            r_rd_seq     <= w_rd_nxt;
            r_replay_num <= w_rn_nxt;
            // Registered so tx_ready stays low during reset yet equals (IDLE && !full) afterwards.
            r_tx_ready   <= (w_state_nxt == ST_IDLE) && (w_count_nxt != FULL_CNT);
            // The buffer returns data one cycle after buf_oe, so the tag follows by one cycle too.
            r_rp_valid   <= w_issue;
            r_rp_seq     <= r_rd_seq;
            r_dllp_err   <= w_range_err;
        end
    end

    replay_timer #(
        .TIMER_W (TIMER_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_timer_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_enable   (w_timer_en),
        .o_expire   (w_expire)
    );

    assign bus.tx_ready      = r_tx_ready;
    assign bus.tx_seq        = r_next_seq;
    assign bus.buf_we        = w_accept;
    assign bus.buf_waddr     = r_next_seq[DEPTH_LOG2-1:0];
    assign bus.buf_oe        = w_issue;
    assign bus.buf_raddr     = r_rd_seq[DEPTH_LOG2-1:0];
    assign bus.rp_valid      = r_rp_valid;
    assign bus.rp_seq        = r_rp_seq;
    assign bus.replay_active = (r_state != ST_IDLE);
    assign bus.retrain_req   = (r_state == ST_RETRAIN);
    assign bus.dllp_err      = r_dllp_err;
    assign bus.count         = w_count[DEPTH_LOG2:0];

endmodule

// File: tb/tb_replay_ctrl.sv
// tb/tb_replay_ctrl.sv - directed self-checking bench for replay_ctrl
module tb_replay_ctrl;
    import replay_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_next  = 0;
    int   n_wait;

    replay_ctrl_if #(.DEPTH_LOG2(3)) bus();

    replay_ctrl #(
        .DEPTH_LOG2 (3),
        .TIMER_W    (10),
        .TIMEOUT    (700),
        .MAX_REPLAY (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_in();
        bus.tx_valid     = 1'b0;
        bus.dllp_valid   = 1'b0;
        bus.dllp_type    = DLLP_NONE;
        bus.dllp_seq     = '0;
        bus.rp_ready     = 1'b0;
        bus.retrain_done = 1'b0;
    endtask

    task automatic dllp(input logic [1:0] t, input int s);
        bus.dllp_valid = 1'b1;
        bus.dllp_type  = t;
        bus.dllp_seq   = 12'(s);
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tx_valid = 1'b1;
            #1;
            check("tx_ready", bus.tx_ready, 1);
            check("buf_we", bus.buf_we, 1);
            check("tx_seq", bus.tx_seq, m_next % 4096);
            check("buf_waddr", bus.buf_waddr, m_next % 8);
            m_next = (m_next + 1) % 4096;
            tick();
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic ack(input int s);
        dllp(DLLP_ACK, s);
        tick();
        bus.dllp_valid = 1'b0;
    endtask

    task automatic wait_active(output int n);
        n = 0;
        while (!bus.replay_active && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr_in();
        bus.tx_valid = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_tx_ready", bus.tx_ready, 0);
        check("rst_buf_we", bus.buf_we, 0);
        check("rst_count", bus.count, 0);
        check("rst_rp_valid", bus.rp_valid, 0);
        check("rst_active", bus.replay_active, 0);
        bus.tx_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        #1;
        check("post_rst_tx_ready", bus.tx_ready, 1);

        // three words, ACK seq 1
        send(3);
        #1;
        check("t1_count3", bus.count, 3);
        ack(1);
        #1;
        check("t1_count1", bus.count, 1);
        check("t1_timer", dut.u_timer.r_timer, 0);
        ack(2);

        // fill all 8 entries, 9th held off
        send(8);
        bus.tx_valid = 1'b1;
        #1;
        check("t2_full_ready", bus.tx_ready, 0);
        check("t2_full_we", bus.buf_we, 0);
        check("t2_full_count", bus.count, 8);
        dllp(DLLP_ACK, 10);
        tick();
        bus.dllp_valid = 1'b0;
        bus.tx_valid   = 1'b0;
        #1;
        check("t2_ready_again", bus.tx_ready, 1);
        check("t2_count0", bus.count, 0);

        // 4 outstanding (11..14), NAK 12 replays 13,14
        send(4);
        bus.rp_ready = 1'b1;
        dllp(DLLP_NAK, 12);
        tick();
        bus.dllp_valid = 1'b0;
        #1;
        check("t3_active", bus.replay_active, 1);
        check("t3_oe0", bus.buf_oe, 1);
        check("t3_raddr0", bus.buf_raddr, 5);
        check("t3_rpv0", bus.rp_valid, 0);
        check("t3_tx_ready", bus.tx_ready, 0);
        tick();
        #1;
        check("t3_oe1", bus.buf_oe, 1);
        check("t3_raddr1", bus.buf_raddr, 6);
        check("t3_rpv1", bus.rp_valid, 1);
        check("t3_rpseq1", bus.rp_seq, 13);
        tick();
        #1;
        check("t3_rpv2", bus.rp_valid, 1);
        check("t3_rpseq2", bus.rp_seq, 14);
        check("t3_oe2", bus.buf_oe, 0);
        check("t3_idle", bus.replay_active, 0);
        check("t3_count", bus.count, 2);
        check("t3_ready", bus.tx_ready, 1);
        bus.rp_ready = 1'b0;
        ack(14);

        // timeout replays of seq 15, escalation to retrain on the 4th
        bus.rp_ready = 1'b1;
        send(1);
        for (int r = 1; r <= 4; r++) begin
            wait_active(n_wait);
            check("t4_timeout_lat", n_wait, 700);
            #1;
            if (r < 4) begin
                check("t4_oe", bus.buf_oe, 1);
                check("t4_raddr", bus.buf_raddr, 7);
                check("t4_no_retrain", bus.retrain_req, 0);
                tick();
                #1;
                check("t4_rpv", bus.rp_valid, 1);
                check("t4_rpseq", bus.rp_seq, 15);
                check("t4_back_idle", bus.replay_active, 0);
                check("t4_replay_num", dut.r_replay_num, r);
            end else begin
                check("t4_retrain", bus.retrain_req, 1);
                check("t4_retrain_oe", bus.buf_oe, 0);
            end
        end
        tick();
        tick();
        #1;
        check("t4_retrain_hold", bus.retrain_req, 1);
        check("t4_retrain_hold_oe", bus.buf_oe, 0);
        bus.retrain_done = 1'b1;
        tick();
        bus.retrain_done = 1'b0;
        #1;
        check("t4_rt_req_off", bus.retrain_req, 0);
        check("t4_rt_replay", bus.replay_active, 1);
        check("t4_rt_oe", bus.buf_oe, 1);
        check("t4_rt_raddr", bus.buf_raddr, 7);
        check("t4_rt_num", dut.r_replay_num, 0);
        tick();
        #1;
        check("t4_rt_rpv", bus.rp_valid, 1);
        check("t4_rt_rpseq", bus.rp_seq, 15);
        check("t4_rt_idle", bus.replay_active, 0);
        bus.rp_ready = 1'b0;
        ack(15);

        // advance to seq 4094, streaming with a trailing ACK each cycle
        while (m_next != 4094) begin
            bus.tx_valid = 1'b1;
            dllp(DLLP_ACK, (m_next + 4095) % 4096);
            tick();
            m_next = m_next + 1;
        end
        bus.tx_valid = 1'b0;
        ack(4093);
        #1;
        check("t5_count0", bus.count, 0);
        check("t5_seq4094", bus.tx_seq, 4094);
        send(4);
        #1;
        check("t5_count4", bus.count, 4);
        ack(0);
        #1;
        check("t5_wrap_count", bus.count, 1);
        ack(100);
        #1;
        check("t5_err", bus.dllp_err, 1);
        check("t5_err_count", bus.count, 1);
        check("t5_err_idle", bus.replay_active, 0);
        tick();
        #1;
        check("t5_err_pulse", bus.dllp_err, 0);
        ack(1);

        // replay of 2..5 with ACK 4 arriving while rd_seq=3
        send(4);
        bus.rp_ready = 1'b1;
        dllp(DLLP_NAK, 1);
        tick();
        bus.dllp_valid = 1'b0;
        #1;
        check("t6_oe0", bus.buf_oe, 1);
        check("t6_raddr0", bus.buf_raddr, 2);
        check("t6_active", bus.replay_active, 1);
        tick();
        bus.rp_ready = 1'b0;
        dllp(DLLP_ACK, 4);
        #1;
        check("t6_stall_oe", bus.buf_oe, 0);
        check("t6_rpv", bus.rp_valid, 1);
        check("t6_rpseq", bus.rp_seq, 2);
        tick();
        bus.dllp_valid = 1'b0;
        bus.rp_ready   = 1'b1;
        #1;
        check("t6_rpv_off", bus.rp_valid, 0);
        check("t6_jump_oe", bus.buf_oe, 1);
        check("t6_jump_raddr", bus.buf_raddr, 5);
        check("t6_count", bus.count, 1);
        check("t6_still_active", bus.replay_active, 1);
        tick();
        #1;
        check("t6_rpv5", bus.rp_valid, 1);
        check("t6_rpseq5", bus.rp_seq, 5);
        check("t6_idle", bus.replay_active, 0);

        // reset asserted mid-replay
        send(3);
        dllp(DLLP_NAK, 4);
        tick();
        bus.dllp_valid = 1'b0;
        tick();
        #1;
        check("t7_rpv_pre", bus.rp_valid, 1);
        reset = 1'b0;
        #1;
        check("t7_rpv", bus.rp_valid, 0);
        check("t7_count", bus.count, 0);
        check("t7_idle", bus.replay_active, 0);
        check("t7_oe", bus.buf_oe, 0);
        check("t7_tx_ready", bus.tx_ready, 0);
        tick();
        reset = 1'b1;
        tick();
        #1;
        check("t7_ready", bus.tx_ready, 1);
        check("t7_seq", bus.tx_seq, 0);
        check("t7_count_after", bus.count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/replay_ctrl.md
Name: replay_ctrl

Overview:
- Sequencing controller for the data-link-layer replay buffer (8 x 16-bit single-port-write / registered-read RAM).
- Assigns 12-bit sequence numbers to outgoing TLP words and drives buffer write/read addressing.
- Retires entries on ACK and triggers replays on NAK or replay-timer expiry.
- Escalates to link retrain after repeated replays.

Parameters:
- DEPTH_LOG2, 3, log2 of buffer entries (one TLP word per entry).
- SEQ_W, 12, sequence number width (mod 4096 arithmetic).
- TIMER_W, 10, replay timer width.
- TIMEOUT, 700, replay timer expiry count in clk cycles.
- MAX_REPLAY, 4, replays allowed before retrain is requested.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- tx_valid  in  1  upstream has a new TLP word.
- tx_ready  out  1  controller accepts the word this cycle.
- tx_seq  out  SEQ_W  sequence number assigned to the accepted word (valid when tx_valid&&tx_ready).
- buf_we  out  1  buffer write enable.
- buf_waddr  out  DEPTH_LOG2  buffer write address.
- buf_oe  out  1  buffer read enable.
- buf_raddr  out  DEPTH_LOG2  buffer read address.
- dllp_valid  in  1  received DLLP strobe.
- dllp_type  in  2  00 none, 01 ACK, 10 NAK, 11 reserved (ignored).
- dllp_seq  in  SEQ_W  AckNak sequence number.
- rp_ready  in  1  link can take a replayed word.
- rp_valid  out  1  replayed word present on buffer dout this cycle.
- rp_seq  out  SEQ_W  sequence number of the replayed word.
- replay_active  out  1  high in REPLAY or RETRAIN.
- retrain_req  out  1  link retrain request.
- retrain_done  in  1  link reports retrain complete.
- dllp_err  out  1  one-cycle pulse on an out-of-range AckNak.
- count  out  DEPTH_LOG2+1  unacknowledged entries.

Behaviour:
- Reset values: next_seq=0, acked_seq=4095, count=0, state=IDLE, timer=0, replay_num=0. All outputs 0 while reset is low; tx_ready is 1 from the first clock after release.
- count = (next_seq - acked_seq - 1) mod 2^SEQ_W. full = (count == 2^DEPTH_LOG2).
- tx_ready = (state==IDLE) && !full.
- On accept:
  - buf_we=1 and buf_waddr=next_seq[DEPTH_LOG2-1:0] in the same cycle.
  - tx_seq=next_seq, then next_seq increments and wraps 4095->0.
- buf_we and buf_oe are never high in the same cycle.
- AckNak processing (dllp_valid with type 01 or 10):
  - d = (dllp_seq - acked_seq) mod 4096.
  - d==0: no purge.
  - 1<=d<=count: acked_seq=dllp_seq; replay_num=0; timer=0.
  - d>count: ignore and pulse dllp_err the next cycle.
- ACK and a new-TLP accept in the same cycle are both applied; count reflects both.
- NAK: purge as for ACK, then enter REPLAY if count after purge > 0. A NAK that leaves count==0 does not replay.
- Timer: increments each cycle in IDLE while count>0. It holds at 0 when count==0, is frozen in REPLAY/RETRAIN and is cleared on entry to and exit from REPLAY. timer==TIMEOUT-1 triggers replay.
- Replay trigger (NAK or timeout, IDLE only):
  - replay_num+1==MAX_REPLAY: go to RETRAIN.
  - Otherwise replay_num++, rd_seq=acked_seq+1, go to REPLAY.
- REPLAY:
  - Each cycle with rp_ready=1: buf_oe=1, buf_raddr=rd_seq[DEPTH_LOG2-1:0], rd_seq++.
  - Next cycle: rp_valid=1, rp_seq equals the issued rd_seq, matching the buffer's 1-cycle read latency. The sink guarantees it accepts every rp_valid beat.
  - Return to IDLE after the read of next_seq-1 has been issued.
  - ACK during REPLAY purges normally; if the new acked_seq >= rd_seq (mod compare), rd_seq jumps to acked_seq+1.
  - If count becomes 0, return to IDLE immediately.
  - NAK or timeout during REPLAY only purges; a replay is not restarted.
- RETRAIN: retrain_req=1 and no buffer reads. On retrain_done: replay_num=0, rd_seq=acked_seq+1, go to REPLAY (or IDLE if count==0).
- Reset low at any point, including mid-replay, aborts the operation and restores all reset values.

Decomposition:
- Package replay_pkg holds:
  - DLLP type constants ACK/NAK/NONE.
  - SEQ_W.
  - State enum {IDLE, REPLAY, RETRAIN}.
  - Function seq_diff(a,b) for the mod-4096 subtract.
- One sub-module: replay_timer, with load/clear/enable inputs and an expire pulse output.

Test Plan:
- Send 3 words, then ACK seq 1 -> tx_seq 0,1,2; buf_waddr 0,1,2; count 3->1; timer cleared.
- Send 8 words with no ACK -> tx_ready drops after the 8th; a 9th tx_valid is held off; ACK seq 7 -> tx_ready=1, count 0.
- 4 outstanding (seq 0-3), NAK seq 1 -> REPLAY; buf_raddr 2,3; rp_seq 2,3 each one cycle after buf_oe; then IDLE, count 2.
- 1 outstanding, no ACK for 700 cycles -> replay issued. Repeat until the 4th trigger -> retrain_req=1; retrain_done -> replay of that entry; replay_num 0.
- next_seq=4094 with 4 words sent (4094,4095,0,1), ACK seq 0 -> count 1; ACK seq 100 -> dllp_err pulse, state unchanged.
- During REPLAY of seq 2..5, ACK seq 4 arrives while rd_seq=3 -> next read is seq 5, then IDLE. Assert reset low mid-replay -> rp_valid=0, count=0, state IDLE.
